mul_share_arb: RTL and testbench
================================

Name: mul_share_arb

Overview:
Shares one combinational 8x8 unsigned multiplier (`mul`, ports mc/mp/p) between NREQ requesters. Each requester presents operands with a valid/ready handshake. A round-robin arbiter picks one operation per cycle and feeds a two-stage registered pipeline. Each result leaves on a single response channel, tagged with the requester ID, with backpressure.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of the requester ID; must equal ceil(log2(NREQ))

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  NREQ  per-requester operation valid
req_mc  input  8*NREQ  multiplicands; requester i in bits [8i+7:8i]
req_mp  input  8*NREQ  multipliers; same packing as req_mc
req_ready  output  NREQ  one-hot grant; combinational
out_valid  output  1  result valid
out_ready  input  1  downstream accepts the result
out_p  output  16  product mc*mp
out_id  output  IDW  index of the requester that issued the operation
ops_done  output  16  count of completed result handshakes; wraps

Behaviour:
- Instantiate `mul` internally. Products are unsigned, full 16 bits, no truncation.
- Reset, asynchronous:
  - s1_valid=0, out_valid=0, out_p=0, out_id=0, ops_done=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has highest priority first.
  - Operand registers cleared to 0.
- Stage-advance conditions:
  - adv2 = !out_valid || out_ready.
  - adv1 = !s1_valid || adv2.
- Arbitration (combinational):
  - Search starts at (last+1) mod NREQ and wraps.
  - The first requester with req_valid set wins, but only if adv1=1.
  - req_ready is one-hot, or all-zero when no request is valid or adv1=0.
  - req_ready[i] never asserts without req_valid[i].
- Transfer happens when req_valid[i] && req_ready[i]. On transfer:
  - s1_mc, s1_mp and s1_id are loaded.
  - s1_valid goes to 1.
  - last is set to i.
  - last changes only on a transfer.
- Stage 1 with adv1=1 and no transfer: s1_valid goes to 0.
- Stage 2 with adv2=1:
  - out_valid takes s1_valid.
  - out_p takes the mul product of s1_mc and s1_mp.
  - out_id takes s1_id.
- Stage 2 with adv2=0: out_* hold stable.
- Latency: transfer in cycle N, then out_valid=1 after the edge ending cycle N+1 (2 edges).
- Throughput: 1 operation per cycle while out_ready=1. A result handshake and a new grant in the same cycle are both performed.
- Backpressure:
  - With out_ready=0, the pipeline accepts until both stages are full. Then req_ready is all-zero.
  - Holds at most 2 in-flight operations.
  - No loss, no duplication, results in grant order.
- ops_done increments by 1 on each out_valid && out_ready edge. 0xFFFF wraps to 0x0000.
- Requester rules:
  - A requester holds req_valid and its operands stable until granted.
  - Withdrawing a request before grant is not supported.
- Reset mid-operation: in-flight operations are discarded. No partial result appears after rst deasserts.

Test Plan:
1. Reset with all req_valid=0 -> req_ready=0, out_valid=0, out_p=0, out_id=0, ops_done=0. Holds for 5 cycles with no activity.
2. Single request, req 0 mc=14 mp=10, out_ready=1 -> req_ready[0]=1 in the same cycle. Two edges later out_valid=1, out_p=140, out_id=0. ops_done=1 after the handshake.
3. All 4 requesters held valid, out_ready=1, req3 mc=0x0A mp=0xF6:
   - Grant order 0,1,2,3,0,1 in consecutive cycles.
   - Output ids appear in the same order.
   - id 3 result is out_p=0x099C (2460).
4. Backpressure, 2 requesters valid, out_ready=0 for 6 cycles:
   - Exactly 2 grants occur, then req_ready=0.
   - out_p/out_id stay stable while stalled.
   - Raise out_ready -> results drain in grant order with no gaps or duplicates. Granting resumes in the same cycle.
5. Operand boundaries -> 255*255 gives out_p=0xFE01; 0*200 gives 0; 1*255 gives 255; 128*2 gives 256.
6. Async reset one cycle after a grant:
   - out_valid=0 and ops_done=0 immediately, before the next clock edge.
   - No result appears after release.
   - With req0 and req2 both valid, the first grant goes to req0.

Source files
------------

// File: rtl/mul_share_arb.sv
// Round-robin sharing of one 8x8 unsigned multiplier between NREQ requesters,
// with a two-stage registered pipeline and a single ID-tagged result channel.

module mul (
  input  logic [7:0]  mc,
  input  logic [7:0]  mp,
  output logic [15:0] p
);
  assign p = 16'(mc) * 16'(mp);
endmodule

module mul_share_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [8*NREQ-1:0]    req_mc,
  input  logic [8*NREQ-1:0]    req_mp,
  output logic [NREQ-1:0]      req_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          out_p,
  output logic [IDW-1:0]       out_id,
  output logic [15:0]          ops_done
);

  logic [IDW-1:0]  last;
  logic [IDW-1:0]  grant_id;
  logic            transfer;
  logic            adv1;
  logic            adv2;
  logic            s1_valid;
  logic [7:0]      s1_mc;
  logic [7:0]      s1_mp;
  logic [IDW-1:0]  s1_id;
  logic [7:0]      sel_mc;
  logic [7:0]      sel_mp;
  logic [15:0]     prod;
  logic [NREQ-1:0] rot;
  int unsigned     idx;

  assign adv2 = !out_valid || out_ready;
  assign adv1 = !s1_valid || adv2;

  // Search starts one past the last winner and wraps; shifts keep index widths clean.
  always_comb begin
    req_ready = '0;
    grant_id  = '0;
    transfer  = 1'b0;
    idx       = 0;
    rot       = '0;
    if (adv1) begin
      for (int unsigned k = 1; k <= NREQ; k++) begin
        idx = (32'(last) + k) % NREQ;
        rot = req_valid >> idx;
        if (!transfer && rot[0]) begin
          req_ready = NREQ'(1) << idx;
          grant_id  = IDW'(idx);
          transfer  = 1'b1;
        end
      end
    end
  end

  assign sel_mc = 8'(req_mc >> {grant_id, 3'b000});
  assign sel_mp = 8'(req_mp >> {grant_id, 3'b000});

  mul u_mul (
    .mc (s1_mc),
    .mp (s1_mp),
    .p  (prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last      <= IDW'(NREQ - 1);
      s1_valid  <= 1'b0;
      s1_mc     <= '0;
      s1_mp     <= '0;
      s1_id     <= '0;
      out_valid <= 1'b0;
      out_p     <= '0;
      out_id    <= '0;
      ops_done  <= '0;
    end else begin
      if (adv1) begin
        s1_valid <= transfer;
        if (transfer) begin
          s1_mc <= sel_mc;
          s1_mp <= sel_mp;
          s1_id <= grant_id;
          last  <= grant_id;
        end
      end
      if (adv2) begin
        out_valid <= s1_valid;
        out_p     <= prod;
        out_id    <= s1_id;
      end
      if (out_valid && out_ready)
        ops_done <= ops_done + 16'd1;
    end
  end

endmodule

// File: tb/tb_mul_share_arb.sv
// Directed bench for mul_share_arb: reset, single op, round-robin streaming,
// backpressure, operand corners and asynchronous reset mid-flight.

module tb_mul_share_arb;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [8*NREQ-1:0]    req_mc;
  logic [8*NREQ-1:0]    req_mp;
  logic [NREQ-1:0]      req_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [15:0]          out_p;
  logic [IDW-1:0]       out_id;
  logic [15:0]          ops_done;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] prod3 [4];
  logic [7:0]  va    [4];
  logic [7:0]  vb    [4];
  logic [15:0] vp    [4];

  always #5 clk = ~clk;

  mul_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_mc    (req_mc),
    .req_mp    (req_mp),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_id    (out_id),
    .ops_done  (ops_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_mc[8*i +: 8] = a;
    req_mp[8*i +: 8] = b;
  endtask

  initial begin
    prod3 = '{16'd2, 16'd12, 16'd30, 16'h099C};
    va    = '{8'd255, 8'd0,   8'd1,   8'd128};
    vb    = '{8'd255, 8'd200, 8'd255, 8'd2};
    vp    = '{16'hFE01, 16'd0, 16'd255, 16'd256};

    rst       = 1'b1;
    req_valid = '0;
    req_mc    = '0;
    req_mp    = '0;
    out_ready = 1'b1;

    // Reset and idle
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_p", 32'(out_p), 32'h0);
    chk("rst_out_id", 32'(out_id), 32'h0);
    chk("rst_ops_done", 32'(ops_done), 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_ready", 32'(req_ready), 32'h0);
      chk("idle_out_valid", 32'(out_valid), 32'h0);
      chk("idle_ops_done", 32'(ops_done), 32'h0);
    end

    // Single request 14*10
    set_op(0, 8'd14, 8'd10);
    req_valid = 4'b0001;
    #1;
    chk("single_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    #1;
    chk("single_lat1_valid", 32'(out_valid), 32'h0);
    tick();
    chk("single_valid", 32'(out_valid), 32'h1);
    chk("single_p", 32'(out_p), 32'd140);
    chk("single_id", 32'(out_id), 32'h0);
    chk("single_ops_pre", 32'(ops_done), 32'h0);
    tick();
    chk("single_ops_post", 32'(ops_done), 32'h1);
    chk("single_drained", 32'(out_valid), 32'h0);

    // Re-reset so the pointer restarts with requester 0 first
    rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;

    // All four requesters streaming
    set_op(0, 8'd1, 8'd2);
    set_op(1, 8'd3, 8'd4);
    set_op(2, 8'd5, 8'd6);
    set_op(3, 8'h0A, 8'hF6);
    for (int c = 0; c < 9; c++) begin
      req_valid = (c < 6) ? 4'b1111 : 4'b0000;
      #1;
      chk("rr_ready", 32'(req_ready), (c < 6) ? (32'h1 << (c % 4)) : 32'h0);
      if (c >= 2 && c < 8) begin
        chk("rr_valid", 32'(out_valid), 32'h1);
        chk("rr_id", 32'(out_id), 32'((c - 2) % 4));
        chk("rr_p", 32'(out_p), 32'(prod3[(c - 2) % 4]));
      end else begin
        chk("rr_idle_valid", 32'(out_valid), 32'h0);
      end
      if (c == 8)
        chk("rr_ops_done", 32'(ops_done), 32'd6);
      tick();
    end

    // Backpressure with requesters 2 and 3
    set_op(2, 8'd7, 8'd9);
    set_op(3, 8'd20, 8'd20);
    req_valid = 4'b1100;
    out_ready = 1'b0;
    #1;
    chk("bp_grant0", 32'(req_ready), 32'h4);
    tick();
    chk("bp_grant1", 32'(req_ready), 32'h8);
    tick();
    for (int c = 2; c < 6; c++) begin
      chk("bp_stall_ready", 32'(req_ready), 32'h0);
      chk("bp_stall_valid", 32'(out_valid), 32'h1);
      chk("bp_stall_p", 32'(out_p), 32'd63);
      chk("bp_stall_id", 32'(out_id), 32'd2);
      if (c == 5)
        chk("bp_stall_ops", 32'(ops_done), 32'd6);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_resume_ready", 32'(req_ready), 32'h4);
    chk("bp_drain0_p", 32'(out_p), 32'd63);
    chk("bp_drain0_id", 32'(out_id), 32'd2);
    tick();
    req_valid = 4'b1000;
    #1;
    chk("bp_resume_ready2", 32'(req_ready), 32'h8);
    chk("bp_drain1_valid", 32'(out_valid), 32'h1);
    chk("bp_drain1_p", 32'(out_p), 32'd400);
    chk("bp_drain1_id", 32'(out_id), 32'd3);
    tick();
    req_valid = '0;
    #1;
    chk("bp_drain2_valid", 32'(out_valid), 32'h1);
    chk("bp_drain2_p", 32'(out_p), 32'd63);
    chk("bp_drain2_id", 32'(out_id), 32'd2);
    tick();
    chk("bp_drain3_valid", 32'(out_valid), 32'h1);
    chk("bp_drain3_p", 32'(out_p), 32'd400);
    chk("bp_drain3_id", 32'(out_id), 32'd3);
    tick();
    chk("bp_done_valid", 32'(out_valid), 32'h0);
    chk("bp_ops_done", 32'(ops_done), 32'd10);
    tick();

    // Operand corners through requester 0
    for (int v = 0; v < 4; v++) begin
      set_op(0, va[v], vb[v]);
      req_valid = 4'b0001;
      #1;
      chk("corner_ready", 32'(req_ready), 32'h1);
      tick();
      req_valid = '0;
      tick();
      chk("corner_valid", 32'(out_valid), 32'h1);
      chk("corner_p", 32'(out_p), 32'(vp[v]));
      chk("corner_id", 32'(out_id), 32'h0);
      tick();
    end
    chk("corner_ops_done", 32'(ops_done), 32'd14);
    chk("corner_idle", 32'(out_valid), 32'h0);

    // Asynchronous reset with both stages occupied
    set_op(0, 8'd3, 8'd3);
    req_valid = 4'b0001;
    #1;
    chk("ar_grant_a", 32'(req_ready), 32'h1);
    tick();
    chk("ar_grant_b", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    chk("ar_live_valid", 32'(out_valid), 32'h1);
    chk("ar_live_p", 32'(out_p), 32'd9);
    chk("ar_live_ops", 32'(ops_done), 32'd14);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_now_valid", 32'(out_valid), 32'h0);
    chk("ar_now_ops", 32'(ops_done), 32'h0);
    chk("ar_now_p", 32'(out_p), 32'h0);
    chk("ar_now_id", 32'(out_id), 32'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ar_quiet_valid", 32'(out_valid), 32'h0);
      chk("ar_quiet_ops", 32'(ops_done), 32'h0);
    end
    set_op(0, 8'd11, 8'd11);
    set_op(2, 8'd12, 8'd12);
    req_valid = 4'b0101;
    #1;
    chk("ar_first_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0100;
    #1;
    chk("ar_second_grant", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    chk("ar_res0_valid", 32'(out_valid), 32'h1);
    chk("ar_res0_p", 32'(out_p), 32'd121);
    chk("ar_res0_id", 32'(out_id), 32'd0);
    tick();
    chk("ar_res1_p", 32'(out_p), 32'd144);
    chk("ar_res1_id", 32'(out_id), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
